// File: rtl/copro_dispatch_if.sv
// rtl/copro_dispatch_if.sv - CPU user-instruction and coprocessor-bank signal bundle
interface copro_dispatch_if #(
  parameter int NUM_UNITS = 4,
  parameter int DATA_W    = 32,
  parameter int OPCODE_W  = 11
);
  logic                        cpu_valid;
  logic [OPCODE_W-1:0]         cpu_opcode;
  logic [DATA_W-1:0]           cpu_op0;
  logic [DATA_W-1:0]           cpu_op1;
  logic                        cpu_accept;
  logic                        cpu_complete;
  logic [DATA_W-1:0]           cpu_result;
  logic [NUM_UNITS-1:0]        u_valid;
  logic [NUM_UNITS-1:0]        u_ready;
  logic [OPCODE_W-1:0]         u_opcode;
  logic [DATA_W-1:0]           u_op0;
  logic [DATA_W-1:0]           u_op1;
  logic [NUM_UNITS-1:0]        u_done;
  logic [NUM_UNITS*DATA_W-1:0] u_result;

  // dispatcher view: answers the CPU, drives the coprocessor bank
  modport master (
    input  cpu_valid, cpu_opcode, cpu_op0, cpu_op1, u_ready, u_done, u_result,
    output cpu_accept, cpu_complete, cpu_result, u_valid, u_opcode, u_op0, u_op1
  );

  // environment view: the CPU and the coprocessor units
  modport slave (
    output cpu_valid, cpu_opcode, cpu_op0, cpu_op1, u_ready, u_done, u_result,
    input  cpu_accept, cpu_complete, cpu_result, u_valid, u_opcode, u_op0, u_op1
  );
endinterface

// File: rtl/copro_dispatch.sv
// rtl/copro_dispatch.sv - routes one LM32 user instruction to one of NUM_UNITS coprocessors
module copro_dispatch #(
  parameter int                NUM_UNITS      = 4,
  parameter int                SEL_W          = 2,
  parameter int                SEL_LSB        = 7,
  parameter int                DATA_W         = 32,
  parameter int                OPCODE_W       = 11,
  parameter int                TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_RESULT     = 32'hDEAD_C0DE
) (
  input  logic             clk,
  input  logic             rst_n,
  copro_dispatch_if.master bus,
  output logic             busy,
  output logic             err_sticky,
  output logic [SEL_W-1:0] err_unit,
  input  logic             err_clr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  // one extra bit so NUM_UNITS == 2**SEL_W is representable
  localparam logic [SEL_W:0]   UNITS    = (SEL_W + 1)'(NUM_UNITS);

  logic [1:0]          state;
  logic [SEL_W-1:0]    sel;
  logic [OPCODE_W-1:0] opc_q;
  logic [DATA_W-1:0]   op0_q;
  logic [DATA_W-1:0]   op1_q;
  logic [DATA_W-1:0]   result_q;
  logic [TMR_W-1:0]    timer;
  logic                first_q;
  logic                unmapped_q;

  logic [SEL_W-1:0]    req_sel;
  logic                req_mapped;
  logic                expired;
  logic                ready_sel;
  logic                done_sel;
  logic [DATA_W-1:0]   res_sel;

  assign req_sel    = bus.cpu_opcode[SEL_LSB +: SEL_W];
  assign req_mapped = ({1'b0, req_sel} < UNITS);
  assign expired    = (timer == TMR_LAST);

  // pick out the selected unit's ready, done and result
  always_comb begin
    ready_sel = 1'b0;
    done_sel  = 1'b0;
    res_sel   = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (sel == SEL_W'(i)) begin
        ready_sel = bus.u_ready[i];
        done_sel  = bus.u_done[i];
        res_sel   = bus.u_result[i*DATA_W +: DATA_W];
      end
    end
  end

  // one-hot issue strobe, only while the request is being offered
  always_comb begin
    bus.u_valid = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      bus.u_valid[i] = (state == S_ISSUE) && (sel == SEL_W'(i));
    end
  end

  // an unmapped request accepts and completes in its single RESP cycle
  assign bus.cpu_accept   = ((state == S_ISSUE) && first_q) || ((state == S_RESP) && unmapped_q);
  assign bus.cpu_complete = (state == S_RESP);
  assign bus.cpu_result   = (state == S_RESP) ? result_q : '0;
  assign bus.u_opcode     = opc_q;
  assign bus.u_op0        = op0_q;
  assign bus.u_op1        = op1_q;
  assign busy             = (state != S_IDLE);

  // request FSM, issue timer and sticky error; an error set overrides err_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sel        <= '0;
      opc_q      <= '0;
      op0_q      <= '0;
      op1_q      <= '0;
      result_q   <= '0;
      timer      <= '0;
      first_q    <= 1'b0;
      unmapped_q <= 1'b0;
      err_sticky <= 1'b0;
      err_unit   <= '0;
    end else begin
      if (err_clr) begin
        err_sticky <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (bus.cpu_valid) begin
            opc_q <= bus.cpu_opcode;
            op0_q <= bus.cpu_op0;
            op1_q <= bus.cpu_op1;
            sel   <= req_sel;
            if (req_mapped) begin
              state      <= S_ISSUE;
              timer      <= '0;
              first_q    <= 1'b1;
              unmapped_q <= 1'b0;
            end else begin
              state      <= S_RESP;
              result_q   <= ERR_RESULT;
              unmapped_q <= 1'b1;
              err_sticky <= 1'b1;
              err_unit   <= req_sel;
            end
          end
        end
        S_ISSUE: begin
          first_q <= 1'b0;
          if (expired) begin
            state      <= S_RESP;
            result_q   <= ERR_RESULT;
            err_sticky <= 1'b1;
            err_unit   <= sel;
          end else begin
            timer <= timer + 1'b1;
            if (ready_sel) begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (done_sel) begin
            state    <= S_RESP;
            result_q <= res_sel;
          end else if (expired) begin
            state      <= S_RESP;
            result_q   <= ERR_RESULT;
            err_sticky <= 1'b1;
            err_unit   <= sel;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          unmapped_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
